// File: rtl/bitwise_pkg.sv
// Shared opcode encoding, skid-buffer state encoding and default width for the
// bitwise operation pipe.
package bitwise_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [2:0] {
    OP_AND   = 3'd0,
    OP_OR    = 3'd1,
    OP_NAND  = 3'd2,
    OP_NOR   = 3'd3,
    OP_XOR   = 3'd4,
    OP_XNOR  = 3'd5,
    OP_PASS_A = 3'd6,
    OP_NOT_A = 3'd7
  } op_e;

  // Encoded as {main_valid, skid_valid} so the state bits double as the flags.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_FULL  = 2'b11
  } skid_state_e;

endpackage

// File: rtl/bitwise_op_unit.sv
// Purely combinational WIDTH-wide gate set; one result selected by opcode.
module bitwise_op_unit
  import bitwise_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    unique case (op)
      OP_AND:    result = a & b;
      OP_OR:     result = a | b;
      OP_NAND:   result = ~(a & b);
      OP_NOR:    result = ~(a | b);
      OP_XOR:    result = a ^ b;
      OP_XNOR:   result = ~(a ^ b);
      OP_PASS_A: result = a;
      OP_NOT_A:  result = ~a;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/bitwise_op_pipe.sv
// Registered valid/ready stage around bitwise_op_unit with a 2-entry skid buffer.
// Optional result parity output is enabled by defining BITWISE_OP_PIPE_PARITY_EN.
module bitwise_op_pipe
  import bitwise_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [2:0]       out_op,
`ifdef BITWISE_OP_PIPE_PARITY_EN
  output logic             out_parity,
`endif
  output logic [CNT_W-1:0] done_cnt
);

  skid_state_e      state_q, state_d;
  logic             accept, drain;
  logic             load_m_new, load_m_skid, load_s;
  logic [WIDTH-1:0] new_result;
  logic [WIDTH-1:0] m_result, s_result;
  logic [2:0]       m_op, s_op;

  bitwise_op_unit #(.WIDTH(WIDTH)) u_unit (
    .a      (in_a),
    .b      (in_b),
    .op     (op_e'(in_op)),
    .result (new_result)
  );

  // Both flags come straight from state flops, so in_ready is registered.
  assign out_valid = state_q[1];
  assign in_ready  = ~state_q[0];
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments in clocked blocks so every flop samples
    // pre-edge values regardless of statement order.
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and infers a latch.
    state_d     = state_q;
    load_m_new  = 1'b0;
    load_m_skid = 1'b0;
    load_s      = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          load_m_new = 1'b1;
          state_d    = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && !out_ready) begin
          load_s  = 1'b1;
          state_d = ST_FULL;
        end else if (accept) begin
          load_m_new = 1'b1;
        end else if (out_ready) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_ready) begin
          load_m_skid = 1'b1;
          state_d     = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // NOTE: the data registers are reset too because out_result/out_op have a
  // defined post-reset value; this is two words, not a memory array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_result <= '0;
      m_op     <= '0;
      s_result <= '0;
      s_op     <= '0;
    end else begin
      if (load_m_new) begin
        m_result <= new_result;
        m_op     <= in_op;
      end else if (load_m_skid) begin
        m_result <= s_result;
        m_op     <= s_op;
      end
      if (load_s) begin
        s_result <= new_result;
        s_op     <= in_op;
      end
    end
  end

`ifdef BITWISE_OP_PIPE_PARITY_EN
  logic m_parity, s_parity;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_parity <= 1'b0;
      s_parity <= 1'b0;
    end else begin
      if (load_m_new)       m_parity <= ^new_result;
      else if (load_m_skid) m_parity <= s_parity;
      if (load_s)           s_parity <= ^new_result;
    end
  end

  assign out_parity = m_parity;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     done_cnt <= '0;
    else if (drain) done_cnt <= done_cnt + CNT_W'(1);
  end

  assign out_result = m_result;
  assign out_op     = m_op;

endmodule

// File: tb/tb_bitwise_op_pipe.sv
// Scoreboard bench for bitwise_op_pipe: truth-table reference model, directed
// cases, backpressure, streaming, random traffic and mid-stream reset.
module tb_bitwise_op_pipe;
  import bitwise_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;
  logic [2:0] in_op = '0;
  logic       out_ready = 1'b0;

  logic        in_ready, out_valid;
  logic [7:0]  out_result;
  logic [2:0]  out_op;
  logic [15:0] done_cnt;

  logic        in_ready4, out_valid4;
  logic [7:0]  out_result4;
  logic [2:0]  out_op4;
  logic [3:0]  done_cnt4;
`ifdef BITWISE_OP_PIPE_PARITY_EN
  logic out_parity, out_parity4;
`endif

  bitwise_op_pipe #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_op(out_op),
`ifdef BITWISE_OP_PIPE_PARITY_EN
    .out_parity(out_parity),
`endif
    .done_cnt(done_cnt)
  );

  // Narrow-counter copy on the same stimulus to exercise counter wrap.
  bitwise_op_pipe #(.WIDTH(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready4),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(out_valid4), .out_ready(out_ready),
    .out_result(out_result4), .out_op(out_op4),
`ifdef BITWISE_OP_PIPE_PARITY_EN
    .out_parity(out_parity4),
`endif
    .done_cnt(done_cnt4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] res;
    logic [2:0] op;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cnt   = 0;
  logic stall_prev = 1'b0;
  logic [7:0] stall_res;
  logic [2:0] stall_op;

  // Output bit = TT[op][{a_bit, b_bit}].
  localparam logic [3:0] TT [8] = '{4'b1000, 4'b1110, 4'b0111, 4'b0001,
                                    4'b0110, 4'b1001, 4'b1100, 4'b0011};

  function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic [2:0] op);
    logic [7:0] r;
    logic [3:0] row;
    row = TT[op];
    for (int i = 0; i < 8; i++) r[i] = row[{a[i], b[i]}];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] op, input logic r, output logic acc);
    exp_t e;
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_op     = op;
    out_ready = r;
    @(negedge clk);
    acc = v && in_ready && rst_n;
    if (acc) begin
      e.res = model(a, b, op);
      e.op  = op;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_expect(input string name, input logic [7:0] a, input logic [7:0] b,
                             input logic [2:0] op, input logic [7:0] exp,
                             input logic exp_par);
    logic acc;
    drive(1'b1, a, b, op, 1'b1, acc);
    check({name, "_accepted"}, 32'(acc), 32'd1);
    in_valid = 1'b0;
    @(negedge clk);
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_result"}, 32'(out_result), 32'(exp));
    check({name, "_op"}, 32'(out_op), 32'(op));
`ifdef BITWISE_OP_PIPE_PARITY_EN
    check({name, "_parity"}, 32'(out_parity), 32'(exp_par));
`else
    if (exp_par === 1'bx) $display("unused parity arg");
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    sb.delete();
    cnt = 0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain_all(input string name);
    logic acc;
    int   n = 0;
    while (sb.size() != 0 && n < 50) begin
      drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, acc);
      n++;
    end
    check({name, "_drained"}, 32'(sb.size()), 32'd0);
  endtask

  // Monitor: compares every presented beat against the scoreboard head.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      check("done_cnt", 32'(done_cnt), 32'(cnt[15:0]));
      check("done_cnt_w4", 32'(done_cnt4), 32'(cnt[3:0]));
      if (stall_prev) begin
        check("stall_valid_held", 32'(out_valid), 32'd1);
        check("stall_result_held", 32'(out_result), 32'(stall_res));
        check("stall_op_held", 32'(out_op), 32'(stall_op));
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: got 0x%0h with empty scoreboard at %0t",
                   out_result, $time);
        end else begin
          check("sb_result", 32'(out_result), 32'(sb[0].res));
          check("sb_op", 32'(out_op), 32'(sb[0].op));
          check("sb_result_w4", 32'(out_result4), 32'(sb[0].res));
`ifdef BITWISE_OP_PIPE_PARITY_EN
          check("sb_parity", 32'(out_parity), 32'(^sb[0].res));
`endif
          if (out_ready) begin
            void'(sb.pop_front());
            cnt++;
          end
        end
      end
      stall_prev = out_valid && !out_ready;
      stall_res  = out_result;
      stall_op   = out_op;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic acc;
    int   tries, n_acc, cycles;

    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_result", 32'(out_result), 32'd0);
    check("rst_out_op", 32'(out_op), 32'd0);
    check("rst_done_cnt", 32'(done_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send_expect("and_cc_aa",  8'hCC, 8'hAA, OP_AND,  8'h88, 1'b0);
    send_expect("or_cc_aa",   8'hCC, 8'hAA, OP_OR,   8'hEE, 1'b0);
    send_expect("nand_cc_aa", 8'hCC, 8'hAA, OP_NAND, 8'h77, 1'b0);
    send_expect("nor_cc_aa",  8'hCC, 8'hAA, OP_NOR,  8'h11, 1'b0);
    check("cnt_after_4", 32'(done_cnt), 32'd4);

    send_expect("and_f0",  8'hF0, 8'h0F, OP_AND,    8'h00, 1'b0);
    send_expect("or_f0",   8'hF0, 8'h0F, OP_OR,     8'hFF, 1'b0);
    send_expect("nand_f0", 8'hF0, 8'h0F, OP_NAND,   8'hFF, 1'b0);
    send_expect("nor_f0",  8'hF0, 8'h0F, OP_NOR,    8'h00, 1'b0);
    send_expect("xor_f0",  8'hF0, 8'h0F, OP_XOR,    8'hFF, 1'b0);
    send_expect("xnor_f0", 8'hF0, 8'h0F, OP_XNOR,   8'h00, 1'b0);
    send_expect("pass_f0", 8'hF0, 8'h0F, OP_PASS_A, 8'hF0, 1'b0);
    send_expect("not_f0",  8'hF0, 8'h0F, OP_NOT_A,  8'h0F, 1'b0);
    send_expect("pass_80", 8'h80, 8'h00, OP_PASS_A, 8'h80, 1'b1);

    // Backpressure: two beats fit, the third waits until the skid drains.
    drive(1'b1, 8'h12, 8'h34, OP_XOR, 1'b0, acc);
    check("bp_acc1", 32'(acc), 32'd1);
    drive(1'b1, 8'h56, 8'h78, OP_OR, 1'b0, acc);
    check("bp_acc2", 32'(acc), 32'd1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'h9A, 8'hBC, OP_AND, 1'b0, acc);
      check("bp_acc3_blocked", 32'(acc), 32'd0);
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
      check("bp_hold_result", 32'(out_result), 32'h26);
      check("bp_hold_op", 32'(out_op), 32'(OP_XOR));
    end
    tries = 0;
    acc = 1'b0;
    while (!acc && tries < 10) begin
      drive(1'b1, 8'h9A, 8'hBC, OP_AND, 1'b1, acc);
      tries++;
    end
    check("bp_acc3_after_release", 32'(tries), 32'd2);
    drain_all("bp");

    // Streaming from a clean counter.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 8'($urandom), 8'($urandom), 3'($urandom), 1'b1, acc);
      check("stream_acc", 32'(acc), 32'd1);
    end
    drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, acc);
    check("stream_done_cnt", 32'(done_cnt), 32'd20);
    check("stream_done_cnt_w4", 32'(done_cnt4), 32'd4);

    // Random traffic on both sides.
    n_acc  = 0;
    cycles = 0;
    while (n_acc < 1000 && cycles < 20000) begin
      drive(($urandom_range(3, 0) != 0), 8'($urandom), 8'($urandom), 3'($urandom),
            1'($urandom), acc);
      if (acc) n_acc++;
      cycles++;
    end
    check("random_beats_accepted", 32'(n_acc), 32'd1000);
    drain_all("random");

    // Fill to FULL, then reset asynchronously mid-cycle.
    tries = 0;
    acc = 1'b1;
    while (acc && tries < 5) begin
      drive(1'b1, 8'($urandom), 8'($urandom), 3'($urandom), 1'b0, acc);
      tries++;
    end
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_out_valid", 32'(out_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_in_ready", 32'(in_ready), 32'd1);
    check("async_rst_done_cnt", 32'(done_cnt), 32'd0);
    check("async_rst_done_cnt_w4", 32'(done_cnt4), 32'd0);
    check("async_rst_result", 32'(out_result), 32'd0);
    in_valid = 1'b0;
    sb.delete();
    cnt = 0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_expect("post_rst_first", 8'hA5, 8'h0F, OP_XOR, 8'hAA, 1'b0);
    check("post_rst_cnt", 32'(done_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
